// File: rtl/sync_regfile.sv
`default_nettype none
// ============================================================================
// sync_regfile : clocked register file, 2 read / 1 write, busy scoreboard
// Revision     : 1.0
// ============================================================================
module sync_regfile #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_SIZE      = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write,
  input  logic [REGADDR_WIDTH-1:0] reg_waddr,
  input  logic [WORD_WIDTH-1:0]    reg_wdata,
  input  logic [REGADDR_WIDTH-1:0] reg_raddr1,
  input  logic [REGADDR_WIDTH-1:0] reg_raddr2,
  output logic [WORD_WIDTH-1:0]    reg_data1,
  output logic [WORD_WIDTH-1:0]    reg_data2,
  input  logic                     set_busy,
  input  logic [REGADDR_WIDTH-1:0] busy_addr,
  output logic                     busy1,
  output logic                     busy2,
  output logic [REGADDR_WIDTH:0]   busy_cnt
);

  localparam logic [REGADDR_WIDTH:0] c_reg_size = (REGADDR_WIDTH+1)'(REG_SIZE);

  logic [WORD_WIDTH-1:0]    r_regs [REG_SIZE];
  logic [REG_SIZE-1:0]      r_busy;
  logic [REGADDR_WIDTH:0]   r_busy_cnt;

  logic                     w_wr_ok;
  logic                     w_set_ok;
  logic                     w_set_new;
  logic                     w_clr;
  logic [REGADDR_WIDTH-1:0] w_raddr [2];
  logic [WORD_WIDTH-1:0]    w_rdata [2];
  logic [1:0]               w_rbusy;

  // In range and not the hardwired zero register
  function automatic logic addr_ok(input logic [REGADDR_WIDTH-1:0] a);
    return ({1'b0, a} < c_reg_size) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wr_ok   = reg_write && addr_ok(reg_waddr);
  assign w_set_ok  = set_busy && addr_ok(busy_addr);
  assign w_set_new = w_set_ok && !r_busy[busy_addr];
  // A write to the address being set leaves the flag busy, so no decrement
  assign w_clr     = w_wr_ok && r_busy[reg_waddr] &&
                     !(w_set_ok && (busy_addr == reg_waddr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[reg_waddr] <= reg_wdata;
        r_busy[reg_waddr] <= 1'b0;
      end
      if (w_set_ok) begin
        r_busy[busy_addr] <= 1'b1;
      end
      case ({w_set_new, w_clr})
        2'b10:   r_busy_cnt <= r_busy_cnt + 1'b1;
        2'b01:   r_busy_cnt <= r_busy_cnt - 1'b1;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign w_raddr[0] = reg_raddr1;
  assign w_raddr[1] = reg_raddr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic w_ok;
    logic w_fwd;
    assign w_ok       = addr_ok(w_raddr[p]);
    assign w_fwd      = (BYPASS != 0) && w_wr_ok && (reg_waddr == w_raddr[p]);
    assign w_rdata[p] = w_fwd ? reg_wdata : (w_ok ? r_regs[w_raddr[p]] : '0);
    assign w_rbusy[p] = w_ok && !w_fwd && r_busy[w_raddr[p]];
  end

  assign reg_data1 = w_rdata[0];
  assign reg_data2 = w_rdata[1];
  assign busy1     = w_rbusy[0];
  assign busy2     = w_rbusy[1];
  assign busy_cnt  = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_regfile.sv
`default_nettype none
// ============================================================================
// tb_sync_regfile : scoreboard bench over three parameter variants
// Revision        : 1.0
// ============================================================================
module tb_sync_regfile;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [4:0]  reg_raddr1;
  logic [4:0]  reg_raddr2;
  logic        set_busy;
  logic [4:0]  busy_addr;

  logic [31:0] d1 [3];
  logic [31:0] d2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic [5:0]  cnt [3];

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // dut 0: defaults, dut 1: no bypass, dut 2: 24 registers
  sync_regfile u_a (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_data1(d1[0]), .reg_data2(d2[0]), .set_busy(set_busy),
    .busy_addr(busy_addr), .busy1(b1[0]), .busy2(b2[0]), .busy_cnt(cnt[0])
  );

  sync_regfile #(.BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_data1(d1[1]), .reg_data2(d2[1]), .set_busy(set_busy),
    .busy_addr(busy_addr), .busy1(b1[1]), .busy2(b2[1]), .busy_cnt(cnt[1])
  );

  sync_regfile #(.REG_SIZE(24)) u_c (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_data1(d1[2]), .reg_data2(d2[2]), .set_busy(set_busy),
    .busy_addr(busy_addr), .busy1(b1[2]), .busy2(b2[2]), .busy_cnt(cnt[2])
  );

  task automatic push(input string n, input int dut, input logic [31:0] e1,
                      input logic [31:0] e2, input logic eb1, input logic eb2,
                      input logic [5:0] ec);
    exp_t e;
    e.name = n; e.dut = dut; e.d1 = e1; e.d2 = e2;
    e.b1 = eb1; e.b2 = eb2; e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic sb, input logic [4:0] ba,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    reg_write = we; reg_waddr = wa; reg_wdata = wd;
    set_busy = sb; busy_addr = ba; reg_raddr1 = ra1; reg_raddr2 = ra2;
  endtask

  // Monitor: combinational outputs are stable mid-cycle, checked on negedge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (d1[e.dut] !== e.d1 || d2[e.dut] !== e.d2 || b1[e.dut] !== e.b1 ||
          b2[e.dut] !== e.b2 || cnt[e.dut] !== e.cnt) begin
        n_fail++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h b1=%b b2=%b cnt=%0d, expected d1=%h d2=%h b1=%b b2=%b cnt=%0d",
                 e.name, e.dut, d1[e.dut], d2[e.dut], b1[e.dut], b2[e.dut], cnt[e.dut],
                 e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    drive(0, 0, 0, 0, 0, 5, 0);
    push("reset_state", 0, 0, 0, 0, 0, 0);
    tick();

    drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5);
    push("r5_both_ports", 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    push("r5_both_ports_24", 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    push("r0_reads_zero", 0, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();

    drive(1, 0, 32'h12345678, 1, 0, 0, 0);
    push("r0_write_no_bypass", 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    push("r0_still_zero", 0, 0, 0, 0, 0, 0);
    tick();

    drive(1, 7, 32'hA5A5A5A5, 0, 0, 7, 5);
    push("bypass_same_cycle", 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0);
    push("nobypass_old_value", 1, 0, 32'hDEADBEEF, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 5);
    push("nobypass_next_cycle", 1, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0);
    tick();

    drive(0, 0, 0, 1, 3, 3, 4);
    push("set_r3_not_yet", 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4, 3, 4);
    push("r3_busy", 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 3, 4);
    push("busy_cnt_2", 0, 0, 0, 1, 1, 2);
    tick();
    drive(1, 3, 32'h33, 0, 0, 3, 4);
    push("clear_write_bypass", 0, 32'h33, 0, 0, 1, 2);
    push("clear_write_nobypass", 1, 0, 0, 1, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 3, 4);
    push("after_clear", 0, 32'h33, 0, 0, 1, 1);
    push("after_clear_nobypass", 1, 32'h33, 0, 0, 1, 1);
    tick();
    drive(1, 4, 32'h44, 1, 4, 4, 3);
    push("set_and_write_same", 0, 32'h44, 32'h33, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 4, 3);
    push("set_wins", 0, 32'h44, 32'h33, 1, 0, 1);
    tick();

    // Fill r1..r31; marks r10..r14 busy after they have been written
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'h01010101 * i, (i >= 20 && i <= 24), 5'(i - 10), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 10, 4);
    push("filled_5_busy", 0, 32'h0A0A0A0A, 32'h04040404, 1, 0, 5);
    push("filled_5_busy_24", 2, 32'h0A0A0A0A, 32'h04040404, 1, 0, 5);
    tick();

    rst_n = 1'b0;
    drive(1, 1, 32'hFFFFFFFF, 1, 2, 10, 4);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 10, 1);
    push("mid_run_reset", 0, 0, 0, 0, 0, 0);
    push("mid_run_reset_24", 2, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 31, 2);
    push("mid_run_reset_r31_r2", 0, 0, 0, 0, 0, 0);
    tick();

    drive(1, 30, 32'hCAFE0030, 1, 30, 30, 30);
    push("oob_write_24", 2, 0, 0, 0, 0, 0);
    push("r30_bypass_32", 0, 32'hCAFE0030, 32'hCAFE0030, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 30, 30);
    push("oob_dropped_24", 2, 0, 0, 0, 0, 0);
    push("r30_stored_32", 0, 32'hCAFE0030, 32'hCAFE0030, 1, 1, 1);
    tick();

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
